// File: rtl/beta_regfile_if.sv
// Register-file port bundle: two read addresses, stall, one write port, two read data.
// Latency: n/a (wires only).
// Backpressure: stall freezes the registered read outputs; writes are never blocked.
interface beta_regfile_if;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        stall;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        WERF;
  logic [31:0] rd1;
  logic [31:0] rd2;

  // Pipeline side: drives addresses, stall and writeback, receives read data.
  modport master (
    output ra1, ra2, stall, wa, wd, WERF,
    input  rd1, rd2
  );

  // Register file side.
  modport slave (
    input  ra1, ra2, stall, wa, wd, WERF,
    output rd1, rd2
  );
endinterface

// File: rtl/beta_regfile.sv
// Beta 2-read/1-write register file, R31 hardwired to zero; option macro BETA_RF_BYPASS_EN.
// Latency: reads registered, data appears one clk after the address; writes land on the edge.
// Backpressure: stall holds rd1/rd2 and ignores ra1/ra2; writes proceed regardless of stall.
module beta_regfile (
  input  logic            clk,
  input  logic            reset,
  beta_regfile_if.slave   bus
);

  // R0..R30 only; R31 has no storage and reads as zero.
  logic [31:0] regs [31];
  logic [31:0] nxt_rd1;
  logic [31:0] nxt_rd2;
  logic        wr_en;

  // A write to address 31 is silently dropped.
  assign wr_en = bus.WERF && (bus.wa != 5'd31);

  // Read-port data selection: zero for R31, otherwise the array (or the
  // incoming write data when write-through is built in and addresses collide).
  always_comb begin
    nxt_rd1 = (bus.ra1 == 5'd31) ? 32'h0 : regs[bus.ra1];
    nxt_rd2 = (bus.ra2 == 5'd31) ? 32'h0 : regs[bus.ra2];
`ifdef BETA_RF_BYPASS_EN
    if (wr_en && (bus.wa == bus.ra1)) nxt_rd1 = bus.wd;
    if (wr_en && (bus.wa == bus.ra2)) nxt_rd2 = bus.wd;
`endif
  end

  // Storage update: reset clears every register and discards any write on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) regs[i] <= 32'h0;
    end else if (wr_en) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  // Registered read outputs: cleared by reset, frozen while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd1 <= 32'h0;
      bus.rd2 <= 32'h0;
    end else if (!bus.stall) begin
      bus.rd1 <= nxt_rd1;
      bus.rd2 <= nxt_rd2;
    end
  end

endmodule
